// File: rtl/simd_wb_arbiter.sv
// SIMD register-file write-back arbiter: per-source result FIFOs feeding NUM_WB
// write ports through an address-conflict-aware round-robin grant.
module simd_wb_arbiter #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned NUM_WB     = 2,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned PHVREG_W   = 6,
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned TAG_W      = 6
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic [NUM_SRC-1:0]           src_valid_i,
   output logic [NUM_SRC-1:0]           src_ready_o,
   input  logic [NUM_SRC*PHVREG_W-1:0]  src_addr_i,
   input  logic [NUM_SRC*DATA_W-1:0]    src_data_i,
   input  logic [NUM_SRC*TAG_W-1:0]     src_tag_i,
   output logic [NUM_WB-1:0]            wr_en_o,
   output logic [NUM_WB*PHVREG_W-1:0]   wr_addr_o,
   output logic [NUM_WB*DATA_W-1:0]     wr_data_o,
   output logic [NUM_WB*TAG_W-1:0]      wr_tag_o
);

   localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [PHVREG_W-1:0] addr_mem_q [NUM_SRC][FIFO_DEPTH];
   logic [DATA_W-1:0]   data_mem_q [NUM_SRC][FIFO_DEPTH];
   logic [TAG_W-1:0]    tag_mem_q  [NUM_SRC][FIFO_DEPTH];
   logic [PTR_W-1:0]    rd_ptr_q   [NUM_SRC];
   logic [PTR_W-1:0]    wr_ptr_q   [NUM_SRC];
   logic [CNT_W-1:0]    count_q    [NUM_SRC];

   logic [PHVREG_W-1:0] head_addr [NUM_SRC];
   logic [DATA_W-1:0]   head_data [NUM_SRC];
   logic [TAG_W-1:0]    head_tag  [NUM_SRC];

   logic [NUM_SRC-1:0]  push;
   logic [NUM_SRC-1:0]  pop;
   logic [SRC_W-1:0]    rr_q, rr_d;

   logic [NUM_WB-1:0]          wr_en_q, wr_en_d;
   logic [NUM_WB*PHVREG_W-1:0] wr_addr_q, wr_addr_d;
   logic [NUM_WB*DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [NUM_WB*TAG_W-1:0]    wr_tag_q, wr_tag_d;

   always_comb begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         src_ready_o[s] = ~rst_i & (count_q[s] != CNT_W'(FIFO_DEPTH));
         head_addr[s]   = addr_mem_q[s][rd_ptr_q[s]];
         head_data[s]   = data_mem_q[s][rd_ptr_q[s]];
         head_tag[s]    = tag_mem_q[s][rd_ptr_q[s]];
      end
      push = src_valid_i & src_ready_o;
   end

   // Scan from rr_q; a head whose address matches an earlier grant is skipped
   // this cycle and left at its FIFO head.
   logic [SRC_W-1:0] scan;
   int unsigned      ngrant;
   logic             clash;

   always_comb begin
      pop       = '0;
      rr_d      = rr_q;
      wr_en_d   = '0;
      wr_addr_d = '0;
      wr_data_d = '0;
      wr_tag_d  = '0;
      ngrant    = 0;
      scan      = '0;
      clash     = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         scan  = SRC_W'((32'(rr_q) + i) % NUM_SRC);
         clash = 1'b0;
         for (int unsigned k = 0; k < NUM_WB; k++) begin
            if (k < ngrant && wr_addr_d[k*PHVREG_W +: PHVREG_W] == head_addr[scan]) clash = 1'b1;
         end
         if (count_q[scan] != '0 && ngrant < NUM_WB && !clash) begin
            pop[scan] = 1'b1;
            for (int unsigned k = 0; k < NUM_WB; k++) begin
               if (k == ngrant) begin
                  wr_en_d[k]                         = 1'b1;
                  wr_addr_d[k*PHVREG_W +: PHVREG_W]  = head_addr[scan];
                  wr_data_d[k*DATA_W +: DATA_W]      = head_data[scan];
                  wr_tag_d[k*TAG_W +: TAG_W]         = head_tag[scan];
               end
            end
            ngrant = ngrant + 1;
            rr_d   = SRC_W'((32'(scan) + 1) % NUM_SRC);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         if (push[s]) begin
            addr_mem_q[s][wr_ptr_q[s]] <= src_addr_i[s*PHVREG_W +: PHVREG_W];
            data_mem_q[s][wr_ptr_q[s]] <= src_data_i[s*DATA_W +: DATA_W];
            tag_mem_q[s][wr_ptr_q[s]]  <= src_tag_i[s*TAG_W +: TAG_W];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         if (rst_i) rr_q <= '0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_tag_q  <= '0;
         for (int unsigned s = 0; s < NUM_SRC; s++) begin
            rd_ptr_q[s] <= '0;
            wr_ptr_q[s] <= '0;
            count_q[s]  <= '0;
         end
      end else begin
         rr_q      <= rr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_tag_q  <= wr_tag_d;
         for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + PTR_W'(1);
            if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(1);
            count_q[s] <= count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
         end
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign wr_tag_o  = wr_tag_q;

endmodule

// File: tb/tb_simd_wb_arbiter.sv
// Directed bench for simd_wb_arbiter: per-source item lists are offered with
// valid/ready, and each cycle's write ports are compared to hand-derived values.
module tb_simd_wb_arbiter;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         flush_i = 1'b0;
   logic [3:0]   src_valid_i = '0;
   logic [3:0]   src_ready_o;
   logic [23:0]  src_addr_i = '0;
   logic [511:0] src_data_i = '0;
   logic [23:0]  src_tag_i = '0;
   logic [1:0]   wr_en_o;
   logic [11:0]  wr_addr_o;
   logic [255:0] wr_data_o;
   logic [11:0]  wr_tag_o;

   simd_wb_arbiter #(.NUM_SRC(4), .NUM_WB(2), .FIFO_DEPTH(2), .PHVREG_W(6), .DATA_W(128), .TAG_W(6)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
      .src_addr_i(src_addr_i), .src_data_i(src_data_i), .src_tag_i(src_tag_i),
      .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_tag_o(wr_tag_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;
   logic [5:0] it_addr [4][4];
   logic [5:0] it_tag  [4][4];
   int n_items [4];
   int idx     [4];

   function automatic logic [127:0] mkdata(input logic [5:0] t);
      return {16{2'b10, t}};
   endfunction

   task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic chk_wb(input string name, input logic [1:0] en,
                         input logic [5:0] a1, input logic [5:0] a0,
                         input logic [5:0] t1, input logic [5:0] t0);
      logic [255:0] exp_data;
      exp_data = {en[1] ? mkdata(t1) : 128'h0, en[0] ? mkdata(t0) : 128'h0};
      chk({name, "_en"},   256'(wr_en_o),   256'(en));
      chk({name, "_addr"}, 256'(wr_addr_o), 256'({a1, a0}));
      chk({name, "_tag"},  256'(wr_tag_o),  256'({t1, t0}));
      chk({name, "_data"}, wr_data_o,       exp_data);
   endtask

   task automatic clear_src();
      for (int s = 0; s < 4; s++) begin
         n_items[s] = 0;
         idx[s]     = 0;
      end
   endtask

   task automatic add_item(input int s, input logic [5:0] a, input logic [5:0] t);
      it_addr[s][n_items[s]] = a;
      it_tag[s][n_items[s]]  = t;
      n_items[s]++;
   endtask

   task automatic drive();
      for (int s = 0; s < 4; s++) begin
         if (idx[s] < n_items[s]) begin
            src_valid_i[s]          = 1'b1;
            src_addr_i[s*6 +: 6]    = it_addr[s][idx[s]];
            src_tag_i[s*6 +: 6]     = it_tag[s][idx[s]];
            src_data_i[s*128 +: 128] = mkdata(it_tag[s][idx[s]]);
         end else begin
            src_valid_i[s]          = 1'b0;
            src_addr_i[s*6 +: 6]    = '0;
            src_tag_i[s*6 +: 6]     = '0;
            src_data_i[s*128 +: 128] = '0;
         end
      end
   endtask

   task automatic tick();
      logic [3:0] rdy, vld;
      drive();
      rdy = src_ready_o;
      vld = src_valid_i;
      @(posedge clk_i);
      #1;
      for (int s = 0; s < 4; s++) if (vld[s] && rdy[s]) idx[s]++;
      drive();
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      flush_i = 1'b0;
      clear_src();
      tick();
      chk_wb("rst", 2'b00, 0, 0, 0, 0);
      chk("rst_rdy", 256'(src_ready_o), 256'(4'b0000));
      tick();
      rst_i = 1'b0;
      #1;
      chk("post_rst_rdy", 256'(src_ready_o), 256'(4'b1111));
   endtask

   // Three items per source, addr 16+4s+n, tag 8s+n.
   task automatic load_stream();
      clear_src();
      for (int s = 0; s < 4; s++)
         for (int n = 0; n < 3; n++) add_item(s, 6'(16 + 4*s + n), 6'(8*s + n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // single push
      add_item(0, 6'd5, 6'd3);
      tick(); chk_wb("single_e1", 2'b00, 0, 0, 0, 0);
      chk("single_rdy1", 256'(src_ready_o), 256'(4'b1111));
      tick(); chk_wb("single_e2", 2'b01, 0, 5, 0, 3);
      chk("single_rdy2", 256'(src_ready_o), 256'(4'b1111));
      tick(); chk_wb("single_e3", 2'b00, 0, 0, 0, 0);

      // four distinct addresses, then rr back at 0
      do_reset();
      for (int s = 0; s < 4; s++) add_item(s, 6'(s + 1), 6'(8 + s));
      tick(); chk_wb("four_e1", 2'b00, 0, 0, 0, 0);
      tick(); chk_wb("four_e2", 2'b11, 2, 1, 9, 8);
      tick(); chk_wb("four_e3", 2'b11, 4, 3, 11, 10);
      tick(); chk_wb("four_e4", 2'b00, 0, 0, 0, 0);
      clear_src();
      add_item(0, 6'd8, 6'd20);
      add_item(3, 6'd8, 6'd23);
      tick(); chk_wb("rr0_e5", 2'b00, 0, 0, 0, 0);
      tick(); chk_wb("rr0_e6", 2'b01, 0, 8, 0, 20);
      tick(); chk_wb("rr0_e7", 2'b01, 0, 8, 0, 23);
      tick(); chk_wb("rr0_e8", 2'b00, 0, 0, 0, 0);

      // address conflict with rr=1
      do_reset();
      add_item(0, 6'd5, 6'd1);
      tick();
      clear_src();
      add_item(1, 6'd7, 6'd2);
      add_item(2, 6'd7, 6'd3);
      add_item(3, 6'd9, 6'd4);
      tick(); chk_wb("conf_e2", 2'b01, 0, 5, 0, 1);
      tick(); chk_wb("conf_e3", 2'b11, 9, 7, 4, 2);
      tick(); chk_wb("conf_e4", 2'b01, 0, 7, 0, 3);
      tick(); chk_wb("conf_e5", 2'b00, 0, 0, 0, 0);

      // backpressure
      do_reset();
      load_stream();
      tick(); chk_wb("bp_e1", 2'b00, 0, 0, 0, 0);
      chk("bp_rdy1", 256'(src_ready_o), 256'(4'b1111));
      tick(); chk_wb("bp_e2", 2'b11, 20, 16, 8, 0);
      chk("bp_rdy2", 256'(src_ready_o), 256'(4'b0011));
      tick(); chk_wb("bp_e3", 2'b11, 28, 24, 24, 16);
      chk("bp_rdy3", 256'(src_ready_o), 256'(4'b1100));
      tick(); chk_wb("bp_e4", 2'b11, 21, 17, 9, 1);
      tick(); chk_wb("bp_e5", 2'b11, 29, 25, 25, 17);
      tick(); chk_wb("bp_e6", 2'b11, 22, 18, 10, 2);
      tick(); chk_wb("bp_e7", 2'b11, 30, 26, 26, 18);
      tick(); chk_wb("bp_e8", 2'b00, 0, 0, 0, 0);

      // flush with five entries buffered
      do_reset();
      add_item(0, 6'd40, 6'd1); add_item(0, 6'd40, 6'd2);
      add_item(1, 6'd40, 6'd3); add_item(1, 6'd40, 6'd4);
      add_item(2, 6'd40, 6'd5);
      add_item(3, 6'd40, 6'd6);
      tick(); chk_wb("fl_e1", 2'b00, 0, 0, 0, 0);
      tick(); chk_wb("fl_e2", 2'b01, 0, 40, 0, 1);
      chk("fl_rdy2", 256'(src_ready_o), 256'(4'b1101));
      clear_src();
      add_item(3, 6'd41, 6'd7);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk_wb("fl_e3", 2'b00, 0, 0, 0, 0);
      chk("fl_rdy3", 256'(src_ready_o), 256'(4'b1111));
      tick(); chk_wb("fl_e4", 2'b00, 0, 0, 0, 0);
      tick(); chk_wb("fl_e5", 2'b00, 0, 0, 0, 0);
      clear_src();
      add_item(0, 6'd50, 6'd10);
      add_item(1, 6'd50, 6'd11);
      tick(); chk_wb("fl_e6", 2'b00, 0, 0, 0, 0);
      tick(); chk_wb("fl_e7", 2'b01, 0, 50, 0, 11);
      tick(); chk_wb("fl_e8", 2'b01, 0, 50, 0, 10);
      tick(); chk_wb("fl_e9", 2'b00, 0, 0, 0, 0);

      // reset mid-operation
      do_reset();
      load_stream();
      tick();
      tick(); chk_wb("mr_e2", 2'b11, 20, 16, 8, 0);
      tick(); chk_wb("mr_e3", 2'b11, 28, 24, 24, 16);
      do_reset();
      add_item(1, 6'd60, 6'd30);
      add_item(2, 6'd60, 6'd31);
      tick(); chk_wb("mr_p1", 2'b00, 0, 0, 0, 0);
      tick(); chk_wb("mr_p2", 2'b01, 0, 60, 0, 30);
      tick(); chk_wb("mr_p3", 2'b01, 0, 60, 0, 31);
      tick(); chk_wb("mr_p4", 2'b00, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
